// File: rtl/aoc_arith_pkg.sv
// Shared types and default widths for the worksheet-column reducer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package aoc_arith_pkg;

   localparam int DEF_ARG_RANKS          = 4;
   localparam int DEF_ARG_DATA_WIDTH     = 14;
   localparam int DEF_PROBLEM_DATA_WIDTH = DEF_ARG_RANKS * DEF_ARG_DATA_WIDTH;
   localparam int DEF_TOTAL_WIDTH        = 64;
   localparam int COUNT_WIDTH            = 16;

   typedef logic [DEF_ARG_DATA_WIDTH-1:0]     arg_data_t;
   typedef logic [DEF_PROBLEM_DATA_WIDTH-1:0] problem_t;
   typedef logic [DEF_TOTAL_WIDTH-1:0]        total_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDUCE = 2'd1,
      COMMIT = 2'd2
   } state_t;

endpackage

// File: rtl/problem_reducer_if.sv
// Column request / result bundle between arg_stores readback, the reducer and tap_encoder.
// Latency: n/a (wiring only).
// Backpressure: operand_valid/operand_ready handshake; results are a one-cycle pulse, no ready.
// Ports: master drives the column request and clear_total; slave (the reducer) drives the
// ready, the result pulse, the running total, problem count and overflow.
interface problem_reducer_if
   import aoc_arith_pkg::*;
#(
   parameter int ARG_RANKS      = DEF_ARG_RANKS,
   parameter int ARG_DATA_WIDTH = DEF_ARG_DATA_WIDTH,
   parameter int TOTAL_WIDTH    = DEF_TOTAL_WIDTH
);
   localparam int PROBLEM_DATA_WIDTH = ARG_RANKS * ARG_DATA_WIDTH;
   localparam int ARG_COUNT_WIDTH    = $clog2(ARG_RANKS + 1);

   logic                                operand_valid;
   logic                                operand_ready;
   logic                                operand_mult_add;
   logic [ARG_COUNT_WIDTH-1:0]          arg_count;
   logic [ARG_RANKS*ARG_DATA_WIDTH-1:0] rd_arg_data;
   logic                                clear_total;
   logic                                problem_valid;
   logic [PROBLEM_DATA_WIDTH-1:0]       problem_data;
   logic [TOTAL_WIDTH-1:0]              grand_total;
   logic                                grand_total_valid;
   logic [COUNT_WIDTH-1:0]              problem_count;
   logic                                overflow;

   modport master (
      output operand_valid, operand_mult_add, arg_count, rd_arg_data, clear_total,
      input  operand_ready, problem_valid, problem_data, grand_total,
             grand_total_valid, problem_count, overflow
   );

   modport slave (
      input  operand_valid, operand_mult_add, arg_count, rd_arg_data, clear_total,
      output operand_ready, problem_valid, problem_data, grand_total,
             grand_total_valid, problem_count, overflow
   );

endinterface

// File: rtl/problem_reducer_rank_alu.sv
// Single reduction step: partial (+ or *) one argument, truncated to the partial width.
// Latency: combinational.
// Backpressure: none; evaluated every cycle, used only while reducing.
// Ports: partial/arg/mult_add in; result (truncated) and ovf (nonzero bits dropped) out.
module rank_alu
   import aoc_arith_pkg::*;
#(
   parameter int ARG_DATA_WIDTH     = DEF_ARG_DATA_WIDTH,
   parameter int PROBLEM_DATA_WIDTH = DEF_PROBLEM_DATA_WIDTH
) (
   input  logic [PROBLEM_DATA_WIDTH-1:0] partial,
   input  logic [ARG_DATA_WIDTH-1:0]     arg,
   input  logic                          mult_add,
   output logic [PROBLEM_DATA_WIDTH-1:0] result,
   output logic                          ovf
);
   localparam int PW     = PROBLEM_DATA_WIDTH;
   localparam int PROD_W = PROBLEM_DATA_WIDTH + ARG_DATA_WIDTH;
   localparam int SUM_W  = PROBLEM_DATA_WIDTH + 1;

   logic [PROD_W-1:0] prod_full;
   logic [SUM_W-1:0]  sum_full;

   // Widen both operands first so no product or carry bit is lost before the check.
   assign prod_full = PROD_W'(partial) * PROD_W'(arg);
   assign sum_full  = SUM_W'(partial) + SUM_W'(arg);

   always_comb begin
      result = '0;
      ovf    = 1'b0;
      if (mult_add) begin
         result = prod_full[PW-1:0];
         ovf    = |prod_full[PROD_W-1:PW];
      end else begin
         result = sum_full[PW-1:0];
         ovf    = sum_full[PW];
      end
   end

endmodule

// File: rtl/problem_reducer.sv
// Reduces one column of up to ARG_RANKS args by sum/product and accumulates into a grand total.
// Latency: accept to problem_valid = max(n,1)+1 cycles, n = min(arg_count, ARG_RANKS).
// Backpressure: operand_ready is high only in IDLE (pure state decode, no valid->ready path).
// Ports: clk, test_logic_reset (sync, active-high), bus (slave side of problem_reducer_if).
module problem_reducer
   import aoc_arith_pkg::*;
#(
   parameter int ARG_RANKS          = DEF_ARG_RANKS,
   parameter int ARG_DATA_WIDTH     = DEF_ARG_DATA_WIDTH,
   parameter int PROBLEM_DATA_WIDTH = ARG_RANKS * ARG_DATA_WIDTH,
   parameter int TOTAL_WIDTH        = DEF_TOTAL_WIDTH
) (
   input  logic             clk,
   input  logic             test_logic_reset,
   problem_reducer_if.slave bus
);
   localparam int AW = ARG_DATA_WIDTH;
   localparam int PW = PROBLEM_DATA_WIDTH;
   localparam int CW = $clog2(ARG_RANKS + 1);
   // Accumulator width covers the wider of partial and total plus one carry bit.
   localparam int SW = ((PW > TOTAL_WIDTH) ? PW : TOTAL_WIDTH) + 1;

   state_t                         state;
   logic [PW-1:0]                  partial;
   logic [CW-1:0]                  idx;
   logic [CW-1:0]                  n_q;
   logic [CW-1:0]                  n_in;
   logic                           op_q;
   logic [ARG_RANKS*AW-1:0]        args_q;
   logic [AW-1:0]                  sel_arg;
   logic [PW-1:0]                  alu_res;
   logic                           alu_ovf;

   logic                           problem_valid_q;
   logic [PW-1:0]                  problem_data_q;
   logic [TOTAL_WIDTH-1:0]         grand_total_q;
   logic [COUNT_WIDTH-1:0]         problem_count_q;
   logic                           overflow_q;

   logic [TOTAL_WIDTH-1:0]         total_base;
   logic [COUNT_WIDTH-1:0]         count_base;
   logic [SW-1:0]                  acc;
   logic                           total_carry;

   // Oversized rank counts are clamped, not rejected.
   assign n_in = (bus.arg_count > CW'(ARG_RANKS)) ? CW'(ARG_RANKS) : bus.arg_count;

   // Rank select as a compare mux so idx may be wider than the rank address.
   always_comb begin
      sel_arg = '0;
      for (int i = 0; i < ARG_RANKS; i++) begin
         if (idx == CW'(i)) begin
            sel_arg = args_q[i*AW +: AW];
         end
      end
   end

   rank_alu #(
      .ARG_DATA_WIDTH     (AW),
      .PROBLEM_DATA_WIDTH (PW)
   ) u_rank_alu (
      .partial  (partial),
      .arg      (sel_arg),
      .mult_add (op_q),
      .result   (alu_res),
      .ovf      (alu_ovf)
   );

   // A clear coinciding with COMMIT is applied before the add, so the commit lands on zero.
   assign total_base  = bus.clear_total ? '0 : grand_total_q;
   assign count_base  = bus.clear_total ? '0 : problem_count_q;
   assign acc         = SW'(total_base) + SW'(partial);
   assign total_carry = |acc[SW-1:TOTAL_WIDTH];

   always_ff @(posedge clk) begin
      if (test_logic_reset) begin
         state           <= IDLE;
         partial         <= '0;
         idx             <= '0;
         n_q             <= '0;
         op_q            <= 1'b0;
         args_q          <= '0;
         problem_valid_q <= 1'b0;
         problem_data_q  <= '0;
         grand_total_q   <= '0;
         problem_count_q <= '0;
         overflow_q      <= 1'b0;
      end else begin
         problem_valid_q <= 1'b0;

         // Later assignments in the state case take precedence over this clear.
         if (bus.clear_total) begin
            grand_total_q   <= '0;
            problem_count_q <= '0;
            overflow_q      <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (bus.operand_valid) begin
                  args_q  <= bus.rd_arg_data;
                  op_q    <= bus.operand_mult_add;
                  n_q     <= n_in;
                  idx     <= CW'(1);
                  partial <= (n_in == '0) ? '0 : PW'(bus.rd_arg_data[AW-1:0]);
                  state   <= (n_in <= CW'(1)) ? COMMIT : REDUCE;
               end
            end
            REDUCE: begin
               partial <= alu_res;
               if (alu_ovf) begin
                  overflow_q <= 1'b1;
               end
               idx <= idx + CW'(1);
               if (idx == n_q - CW'(1)) begin
                  state <= COMMIT;
               end
            end
            COMMIT: begin
               problem_valid_q <= 1'b1;
               problem_data_q  <= partial;
               grand_total_q   <= acc[TOTAL_WIDTH-1:0];
               problem_count_q <= count_base + COUNT_WIDTH'(1);
               if (total_carry) begin
                  overflow_q <= 1'b1;
               end
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.operand_ready     = (state == IDLE);
   assign bus.grand_total_valid = (state == IDLE);
   assign bus.problem_valid     = problem_valid_q;
   assign bus.problem_data      = problem_data_q;
   assign bus.grand_total       = grand_total_q;
   assign bus.problem_count     = problem_count_q;
   assign bus.overflow          = overflow_q;

endmodule

// File: tb/tb_problem_reducer.sv
// Bench for problem_reducer: vector table plus hand sequences, scoreboard on problem_valid.
// Latency: checks accept-to-result cycle count per column.
// Backpressure: holds operand_valid across busy cycles and checks single acceptance.
module tb_problem_reducer;
   import aoc_arith_pkg::*;

   logic clk = 1'b0;
   logic test_logic_reset;
   always #5 clk = ~clk;

   problem_reducer_if bus ();
   problem_reducer_if #(.TOTAL_WIDTH(16)) bus16 ();

   problem_reducer dut (
      .clk              (clk),
      .test_logic_reset (test_logic_reset),
      .bus              (bus)
   );

   problem_reducer #(.TOTAL_WIDTH(16)) dut16 (
      .clk              (clk),
      .test_logic_reset (test_logic_reset),
      .bus              (bus16)
   );

   typedef struct {
      logic       op;
      logic [2:0] cnt;
      problem_t   args;
      problem_t   exp;
      int         lat;
   } vec_t;

   typedef struct {
      problem_t          data;
      total_t            total;
      logic [15:0]       count;
   } exp_t;

   int          checks   = 0;
   int          failures = 0;
   exp_t        sbq[$];
   exp_t        mon_e;
   total_t      model_total = '0;
   logic [15:0] model_count = '0;
   vec_t        tbl[11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic problem_t mk(input logic [13:0] a0, input logic [13:0] a1,
                                   input logic [13:0] a2, input logic [13:0] a3);
      return {a3, a2, a1, a0};
   endfunction

   task automatic push_exp(input problem_t d, input total_t t, input logic [15:0] c);
      exp_t e;
      model_total = t;
      model_count = c;
      e.data  = d;
      e.total = t;
      e.count = c;
      sbq.push_back(e);
   endtask

   // Scoreboard: every result pulse must match the oldest outstanding column.
   always @(negedge clk) begin
      if (bus.problem_valid === 1'b1) begin
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_commit: got data %0d, expected no commit", bus.problem_data);
         end else begin
            mon_e = sbq.pop_front();
            check("sb_data", 64'(bus.problem_data), 64'(mon_e.data));
            check("sb_total", bus.grand_total, mon_e.total);
            check("sb_count", 64'(bus.problem_count), 64'(mon_e.count));
            check("sb_total_valid", 64'(bus.grand_total_valid), 64'd1);
         end
      end
   end

   task automatic run_col(input string name, input logic op, input logic [2:0] cnt,
                          input problem_t args, input problem_t expv, input int exp_lat);
      int lat;
      int guard;
      push_exp(expv, model_total + total_t'(expv), model_count + 16'd1);
      @(negedge clk);
      bus.operand_valid    = 1'b1;
      bus.operand_mult_add = op;
      bus.arg_count        = cnt;
      bus.rd_arg_data      = args;
      guard = 0;
      while (bus.operand_ready !== 1'b1 && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 50) begin
         check({name, "_accept_timeout"}, 64'(bus.operand_ready), 64'd1);
         bus.operand_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.operand_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      check({name, "_busy_ready"}, 64'(bus.operand_ready), 64'd0);
      check({name, "_busy_gtv"}, 64'(bus.grand_total_valid), 64'd0);
      while (bus.problem_valid !== 1'b1 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({name, "_latency"}, 64'(lat), 64'(exp_lat));
   endtask

   task automatic run16(input logic [2:0] cnt, input problem_t args);
      int guard;
      @(negedge clk);
      bus16.operand_valid    = 1'b1;
      bus16.operand_mult_add = 1'b0;
      bus16.arg_count        = cnt;
      bus16.rd_arg_data      = args;
      @(posedge clk);
      #1;
      bus16.operand_valid = 1'b0;
      guard = 0;
      @(negedge clk);
      while (bus16.problem_valid !== 1'b1 && guard < 40) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 40) begin
         check("w16_commit_timeout", 64'(bus16.problem_valid), 64'd1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      tbl[0]  = '{1'b1, 3'd3, mk(123, 45, 6, 0),        problem_t'(33210),     4};
      tbl[1]  = '{1'b0, 3'd3, mk(328, 64, 98, 0),       problem_t'(490),       4};
      tbl[2]  = '{1'b0, 3'd0, mk(5, 6, 7, 8),           problem_t'(0),         2};
      tbl[3]  = '{1'b1, 3'd0, mk(5, 6, 7, 8),           problem_t'(0),         2};
      tbl[4]  = '{1'b0, 3'd1, mk(9999, 1, 1, 1),        problem_t'(9999),      2};
      tbl[5]  = '{1'b0, 3'd7, mk(1000, 2000, 3000, 4000), problem_t'(10000),   5};
      tbl[6]  = '{1'b1, 3'd4, mk(2, 3, 4, 5),           problem_t'(120),       5};
      tbl[7]  = '{1'b0, 3'd2, mk(16383, 16383, 0, 0),   problem_t'(32766),     3};
      tbl[8]  = '{1'b1, 3'd3, mk(7, 0, 9, 1),           problem_t'(0),         4};
      tbl[9]  = '{1'b1, 3'd2, mk(16383, 16383, 3, 3),   problem_t'(268402689), 3};
      tbl[10] = '{1'b1, 3'd1, mk(12, 99, 99, 99),       problem_t'(12),        2};

      test_logic_reset       = 1'b1;
      bus.operand_valid      = 1'b0;
      bus.operand_mult_add   = 1'b0;
      bus.arg_count          = '0;
      bus.rd_arg_data        = '0;
      bus.clear_total        = 1'b0;
      bus16.operand_valid    = 1'b0;
      bus16.operand_mult_add = 1'b0;
      bus16.arg_count        = '0;
      bus16.rd_arg_data      = '0;
      bus16.clear_total      = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_ready", 64'(bus.operand_ready), 64'd1);
      check("rst_pvalid", 64'(bus.problem_valid), 64'd0);
      check("rst_data", 64'(bus.problem_data), 64'd0);
      check("rst_total", bus.grand_total, 64'd0);
      check("rst_gtv", 64'(bus.grand_total_valid), 64'd1);
      check("rst_count", 64'(bus.problem_count), 64'd0);
      check("rst_ovf", 64'(bus.overflow), 64'd0);
      @(posedge clk);
      #1;
      test_logic_reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run_col($sformatf("vec%0d", i), tbl[i].op, tbl[i].cnt, tbl[i].args, tbl[i].exp, tbl[i].lat);
      end
      @(negedge clk);
      check("vec_no_overflow", 64'(bus.overflow), 64'd0);

      // Valid held high through the busy cycles: column A once, then column B once.
      push_exp(problem_t'(33210), model_total + 64'd33210, model_count + 16'd1);
      push_exp(problem_t'(30), model_total + 64'd30, model_count + 16'd1);
      @(negedge clk);
      bus.operand_valid    = 1'b1;
      bus.operand_mult_add = 1'b1;
      bus.arg_count        = 3'd3;
      bus.rd_arg_data      = mk(123, 45, 6, 0);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.operand_mult_add = 1'b0;
      bus.arg_count        = 3'd2;
      bus.rd_arg_data      = mk(10, 20, 0, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      bus.operand_valid = 1'b0;
      guard = 0;
      while (sbq.size() != 0 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      check("hold_drain", 64'(sbq.size()), 64'd0);
      repeat (3) @(negedge clk);

      // Clear while idle.
      @(negedge clk);
      bus.clear_total = 1'b1;
      @(negedge clk);
      bus.clear_total = 1'b0;
      check("clr_total", bus.grand_total, 64'd0);
      check("clr_count", 64'(bus.problem_count), 64'd0);
      model_total = '0;
      model_count = '0;
      run_col("post_clr", 1'b0, 3'd2, mk(40, 2, 0, 0), problem_t'(42), 3);

      // Clear on the COMMIT cycle: total restarts at this column's value.
      push_exp(problem_t'(300), 64'd300, 16'd1);
      @(negedge clk);
      bus.operand_valid    = 1'b1;
      bus.operand_mult_add = 1'b0;
      bus.arg_count        = 3'd2;
      bus.rd_arg_data      = mk(100, 200, 0, 0);
      @(posedge clk);
      #1;
      bus.operand_valid = 1'b0;
      @(posedge clk);
      #1;
      bus.clear_total = 1'b1;
      @(posedge clk);
      #1;
      bus.clear_total = 1'b0;
      repeat (2) @(negedge clk);
      check("commit_clr_drain", 64'(sbq.size()), 64'd0);

      // Reset during REDUCE aborts the column.
      @(negedge clk);
      bus.operand_valid    = 1'b1;
      bus.operand_mult_add = 1'b1;
      bus.arg_count        = 3'd4;
      bus.rd_arg_data      = mk(2, 3, 4, 5);
      @(posedge clk);
      #1;
      bus.operand_valid = 1'b0;
      test_logic_reset  = 1'b1;
      @(posedge clk);
      #1;
      test_logic_reset = 1'b0;
      @(negedge clk);
      check("abort_ready", 64'(bus.operand_ready), 64'd1);
      check("abort_pvalid", 64'(bus.problem_valid), 64'd0);
      check("abort_data", 64'(bus.problem_data), 64'd0);
      check("abort_total", bus.grand_total, 64'd0);
      check("abort_gtv", 64'(bus.grand_total_valid), 64'd1);
      check("abort_count", 64'(bus.problem_count), 64'd0);
      check("abort_ovf", 64'(bus.overflow), 64'd0);
      model_total = '0;
      model_count = '0;
      repeat (8) @(negedge clk);

      // 16-bit total: wrap sets the sticky overflow, clear drops it.
      run16(3'd4, mk(16383, 16383, 16383, 16383));
      check("w16_total1", 64'(bus16.grand_total), 64'd65532);
      check("w16_ovf1", 64'(bus16.overflow), 64'd0);
      run16(3'd1, mk(10, 0, 0, 0));
      check("w16_data2", 64'(bus16.problem_data), 64'd10);
      check("w16_total2", 64'(bus16.grand_total), 64'd6);
      check("w16_count2", 64'(bus16.problem_count), 64'd2);
      check("w16_ovf2", 64'(bus16.overflow), 64'd1);
      repeat (2) @(negedge clk);
      check("w16_ovf_sticky", 64'(bus16.overflow), 64'd1);
      bus16.clear_total = 1'b1;
      @(negedge clk);
      bus16.clear_total = 1'b0;
      check("w16_clr_total", 64'(bus16.grand_total), 64'd0);
      check("w16_clr_count", 64'(bus16.problem_count), 64'd0);
      check("w16_clr_ovf", 64'(bus16.overflow), 64'd0);

      repeat (2) @(negedge clk);
      check("sb_final_empty", 64'(sbq.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
